// File: rtl/or1k_branch_resolver.sv
// Branch resolution for l.bf / l.bnf: holds the branch in the execute slot,
// compares the predicted flag with the real flag, requests a fetch redirect
// on a mispredict and keeps saturating branch / mispredict counters.
module or1k_branch_resolver #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            pipeline_flush_i,
  input  logic                            decode_op_bf_i,
  input  logic                            decode_op_bnf_i,
  input  logic                            predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_fallthru_i,
  input  logic                            flag_i,
  output logic                            execute_op_bf_o,
  output logic                            execute_op_bnf_o,
  output logic                            prev_op_brcond_o,
  output logic                            branch_mispredict_o,
  output logic                            redirect_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_addr_o,
  input  logic                            redirect_ready_i,
  output logic [CNT_WIDTH-1:0]            branch_count_o,
  output logic [CNT_WIDTH-1:0]            mispredict_count_o
);

  typedef enum logic [0:0] {IDLE, PENDING} state_t;

  state_t                          state, state_nxt;
  logic                            vld_p1;
  logic                            op_bf_p1;
  logic                            op_bnf_p1;
  logic                            pred_flag_p1;
  logic [OPTION_OPERAND_WIDTH-1:0] target_p1;
  logic [OPTION_OPERAND_WIDTH-1:0] fallthru_p1;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_addr;
  logic [CNT_WIDTH-1:0]            branch_count;
  logic [CNT_WIDTH-1:0]            mispredict_count;
  logic                            capture;
  logic                            resolve;
  logic                            mispredict;
  logic                            taken;
  logic                            load_redirect;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Capture happens on a decode advance; a resolution is the advance that
  // pushes a valid branch out of execute. A flush suppresses both.
  assign capture       = padv_decode_i & ~pipeline_flush_i;
  assign resolve       = vld_p1 & capture;
  assign mispredict    = vld_p1 & (flag_i != pred_flag_p1);
  // l.bf wins if both op bits were (illegally) set.
  assign taken         = op_bf_p1 ? flag_i : ~flag_i;
  assign load_redirect = resolve & mispredict;

  // ---- decode -> execute boundary ----
  // Execute slot valid bit: the only control state of the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  vld_p1 <= 1'b0;
    else if (pipeline_flush_i) vld_p1 <= 1'b0;
    else if (padv_decode_i)    vld_p1 <= decode_op_bf_i | decode_op_bnf_i;
  end

  // Execute slot payload; every use is qualified by vld_p1.
  always_ff @(posedge clk) begin
    if (capture) begin
      op_bf_p1     <= decode_op_bf_i;
      op_bnf_p1    <= decode_op_bnf_i;
      pred_flag_p1 <= predicted_flag_i;
      if (decode_op_bf_i | decode_op_bnf_i) begin
        target_p1   <= decode_target_i;
        fallthru_p1 <= decode_fallthru_i;
      end
    end
  end

  // ---- execute -> redirect boundary ----
  // Redirect FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: flush beats everything, a new mispredict overrides a pending one.
  always_comb begin
    state_nxt = state;
    if (pipeline_flush_i)                         state_nxt = IDLE;
    else if (load_redirect)                       state_nxt = PENDING;
    else if (state == PENDING && redirect_ready_i) state_nxt = IDLE;
  end

  // Corrected fetch address, loaded on each mispredicting resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               redirect_addr <= '0;
    else if (load_redirect) redirect_addr <= taken ? target_p1 : fallthru_p1;
  end

  // Saturating performance counters, advanced only on resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve) begin
      branch_count <= sat_inc(branch_count);
      if (mispredict) mispredict_count <= sat_inc(mispredict_count);
    end
  end

  assign execute_op_bf_o     = vld_p1 & op_bf_p1;
  assign execute_op_bnf_o    = vld_p1 & op_bnf_p1;
  assign prev_op_brcond_o    = vld_p1;
  assign branch_mispredict_o = mispredict;
  assign redirect_valid_o    = (state == PENDING);
  assign redirect_addr_o     = redirect_addr;
  assign branch_count_o      = branch_count;
  assign mispredict_count_o  = mispredict_count;

endmodule

// File: tb/tb_or1k_branch_resolver.sv
// Bench for or1k_branch_resolver: directed scenarios followed by random
// traffic, checked by a queue-based scoreboard against a behavioural model.
module tb_or1k_branch_resolver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        padv = 1'b0, flush = 1'b0, bf = 1'b0, bnf = 1'b0, pred = 1'b0;
  logic        flag = 1'b0, ready = 1'b0;
  logic [31:0] tgt = '0, ft = '0;

  logic        ebf, ebnf, brc, mis, rv;
  logic [31:0] ra;
  logic [15:0] bc, mc;
  logic        ebf4, ebnf4, brc4, mis4, rv4;
  logic [31:0] ra4;
  logic [3:0]  bc4, mc4;

  or1k_branch_resolver #(.OPTION_OPERAND_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .padv_decode_i(padv), .pipeline_flush_i(flush),
    .decode_op_bf_i(bf), .decode_op_bnf_i(bnf), .predicted_flag_i(pred),
    .decode_target_i(tgt), .decode_fallthru_i(ft), .flag_i(flag),
    .execute_op_bf_o(ebf), .execute_op_bnf_o(ebnf), .prev_op_brcond_o(brc),
    .branch_mispredict_o(mis), .redirect_valid_o(rv), .redirect_addr_o(ra),
    .redirect_ready_i(ready), .branch_count_o(bc), .mispredict_count_o(mc));

  or1k_branch_resolver #(.OPTION_OPERAND_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .padv_decode_i(padv), .pipeline_flush_i(flush),
    .decode_op_bf_i(bf), .decode_op_bnf_i(bnf), .predicted_flag_i(pred),
    .decode_target_i(tgt), .decode_fallthru_i(ft), .flag_i(flag),
    .execute_op_bf_o(ebf4), .execute_op_bnf_o(ebnf4), .prev_op_brcond_o(brc4),
    .branch_mispredict_o(mis4), .redirect_valid_o(rv4), .redirect_addr_o(ra4),
    .redirect_ready_i(ready), .branch_count_o(bc4), .mispredict_count_o(mc4));

  always #5 clk = ~clk;

  typedef struct {
    logic        ebf, ebnf, brc, mis, rv;
    logic [31:0] ra;
    int          bc, mc, bc4, mc4;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] redir_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Behavioural model: one branch slot in execute plus an optional pending redirect.
  logic        m_v, m_bf, m_bnf, m_pred, m_pend;
  logic [31:0] m_tgt, m_ft, m_addr;
  int          m_bc, m_mc, m_bc4, m_mc4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    m_v = 0; m_bf = 0; m_bnf = 0; m_pred = 0; m_pend = 0;
    m_tgt = '0; m_ft = '0; m_addr = '0;
    m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  // One clock of stimulus: drive, push the expected response, advance the model.
  task automatic cycle(input logic p, input logic fl, input logic b, input logic nb,
                       input logic pr, input logic f, input logic rdy,
                       input logic [31:0] t, input logic [31:0] fa);
    exp_t e;
    logic tk;
    @(posedge clk); #1;
    padv = p; flush = fl; bf = b; bnf = nb; pred = pr; flag = f; ready = rdy;
    tgt = t; ft = fa;
    e.ebf = m_v & m_bf; e.ebnf = m_v & m_bnf; e.brc = m_v;
    e.mis = m_v & (f != m_pred); e.rv = m_pend; e.ra = m_addr;
    e.bc = m_bc; e.mc = m_mc; e.bc4 = m_bc4; e.mc4 = m_mc4;
    cyc_q.push_back(e);
    if (m_pend && rdy && !fl) redir_q.push_back(m_addr);
    if (fl) begin
      m_v = 0; m_pend = 0;
    end else begin
      if (p && m_v) begin
        m_bc  = (m_bc  < 65535) ? m_bc  + 1 : m_bc;
        m_bc4 = (m_bc4 < 15)    ? m_bc4 + 1 : m_bc4;
        if (f != m_pred) begin
          m_mc  = (m_mc  < 65535) ? m_mc  + 1 : m_mc;
          m_mc4 = (m_mc4 < 15)    ? m_mc4 + 1 : m_mc4;
          tk = m_bf ? f : !f;
          m_addr = tk ? m_tgt : m_ft;
          m_pend = 1;
        end else if (m_pend && rdy) m_pend = 0;
      end else if (m_pend && rdy) m_pend = 0;
      if (p) begin
        m_v = b | nb; m_bf = b; m_bnf = nb; m_pred = pr;
        if (b | nb) begin m_tgt = t; m_ft = fa; end
      end
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(0, 0, 0, 0, 0, 0, rdy, 32'h0, 32'h0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    @(posedge clk); #2;
    padv = 0; flush = 0; bf = 0; bnf = 0; ready = 0;
    rst = 0;
    model_clear();
    #1;
    chk("rst_brc", brc, 0);          chk("rst_ebf", ebf, 0);
    chk("rst_ebnf", ebnf, 0);        chk("rst_rv", rv, 0);
    chk("rst_ra", ra, 0);            chk("rst_bc", bc, 0);
    chk("rst_mc", mc, 0);            chk("rst_rv4", rv4, 0);
    chk("rst_bc4", bc4, 0);          chk("rst_mc4", mc4, 0);
    @(negedge clk); #1 rst = 1;
  endtask

  // Monitor: per-cycle expectations plus redirect handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("ebf", ebf, e.ebf);      chk("ebnf", ebnf, e.ebnf);
      chk("brcond", brc, e.brc);   chk("mispredict", mis, e.mis);
      chk("rv", rv, e.rv);         chk("bc", bc, e.bc);
      chk("mc", mc, e.mc);         chk("bc4", bc4, e.bc4);
      chk("mc4", mc4, e.mc4);      chk("rv4", rv4, e.rv);
      if (e.rv) chk("ra_hold", ra, e.ra);
    end
    if (rst && rv && ready && !flush) begin
      if (redir_q.size() == 0) chk("redir_unexpected", 1, 0);
      else chk("redir_addr", ra, redir_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    do_reset();

    // Correct prediction on l.bf.
    cycle(1, 0, 1, 0, 1, 0, 0, 32'h100, 32'h208);
    cycle(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    idle(0);
    @(negedge clk); #1;
    chk("t1_bc", bc, 1); chk("t1_mc", mc, 0); chk("t1_rv", rv, 0);

    // l.bf predicted taken, not taken: redirect to fallthrough.
    do_reset();
    cycle(1, 0, 1, 0, 1, 0, 0, 32'h100, 32'h208);
    cycle(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("t2_mis", mis, 1);
    idle(0);
    @(negedge clk); #1;
    chk("t2_rv", rv, 1); chk("t2_ra", ra, 32'h208); chk("t2_mc", mc, 1);
    idle(1);
    idle(0);

    // l.bnf predicted 1, flag 0: taken to target; hold off ready 3 cycles.
    do_reset();
    cycle(1, 0, 0, 1, 1, 0, 0, 32'h400, 32'h600);
    cycle(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      @(negedge clk); #1;
      chk("t3_rv_hold", rv, 1); chk("t3_ra_hold", ra, 32'h400);
    end
    idle(1);
    idle(0);
    @(negedge clk); #1;
    chk("t3_rv_drop", rv, 0);

    // New mispredict in the same cycle as ready: newest wins.
    do_reset();
    cycle(1, 0, 1, 0, 1, 0, 0, 32'h100, 32'h208);
    cycle(1, 0, 1, 0, 1, 0, 0, 32'h300, 32'h500);
    cycle(1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    idle(0);
    @(negedge clk); #1;
    chk("t4_rv", rv, 1); chk("t4_ra", ra, 32'h500); chk("t4_mc", mc, 2);
    idle(1);
    idle(0);

    // Flush with a branch in execute and a redirect pending.
    do_reset();
    cycle(1, 0, 1, 0, 1, 0, 0, 32'h100, 32'h208);
    cycle(1, 0, 1, 0, 0, 0, 0, 32'h700, 32'h800);
    cycle(1, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    idle(0);
    @(negedge clk); #1;
    chk("t5_brc", brc, 0); chk("t5_rv", rv, 0);
    chk("t5_bc", bc, 1);   chk("t5_mc", mc, 1);

    // 20 back-to-back mispredicts: 4-bit counters saturate.
    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(1, 0, 1, 0, 1, 0, 0, 32'h1000 + i, 32'h2000 + i);
    cycle(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(0);
    @(negedge clk); #1;
    chk("t6_bc4", bc4, 15); chk("t6_mc4", mc4, 15);
    chk("t6_bc", bc, 20);   chk("t6_mc", mc, 20);
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 1, 0, 1, 0, 0, 32'h3000 + i, 32'h4000 + i);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic b, nb;
      r = $urandom_range(0, 7);
      b  = (r <= 2) || (r == 7 && $urandom_range(0, 3) == 0);
      nb = (r >= 3 && r <= 5) || (r == 7 && b);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, b, nb,
                 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
    end
    idle(0);
    idle(0);
    @(negedge clk); #1;
    chk("redir_q_empty", redir_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or1k_branch_resolver.md
# or1k_branch_resolver

Resolution-side partner of the decode-stage branch predictor. It captures each conditional branch (l.bf / l.bnf) and its predicted flag as the branch leaves decode, and compares the prediction with the real flag when the branch resolves. It drives the feedback signals the predictor trains on, and issues a fetch-redirect request with a valid/ready handshake on a mispredict. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- OPTION_OPERAND_WIDTH, 32, width of PC / address fields
- CNT_WIDTH, 16, width of each performance counter

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- padv_decode_i  in  1  decode stage advances this cycle
- pipeline_flush_i  in  1  exception/flush; kills in-flight branch and pending redirect
- decode_op_bf_i  in  1  insn in decode is l.bf
- decode_op_bnf_i  in  1  insn in decode is l.bnf
- predicted_flag_i  in  1  predicted flag value for the decode insn
- decode_target_i  in  OPTION_OPERAND_WIDTH  branch target address
- decode_fallthru_i  in  OPTION_OPERAND_WIDTH  not-taken address (after delay slot)
- flag_i  in  1  architectural flag, valid while the branch sits in execute
- execute_op_bf_o  out  1  registered: execute holds l.bf
- execute_op_bnf_o  out  1  registered: execute holds l.bnf
- prev_op_brcond_o  out  1  execute holds a valid conditional branch
- branch_mispredict_o  out  1  combinational: prev_op_brcond_o & (flag_i != stored prediction)
- redirect_valid_o  out  1  redirect request to fetch
- redirect_addr_o  out  OPTION_OPERAND_WIDTH  corrected fetch address
- redirect_ready_i  in  1  fetch accepts redirect
- branch_count_o  out  CNT_WIDTH  resolved conditional branches, saturating
- mispredict_count_o  out  CNT_WIDTH  mispredicted branches, saturating

## Operation
- Exec slot registers: valid, op_bf, op_bnf, pred_flag, target, fallthru.
- Capture: on padv_decode_i & !pipeline_flush_i:
  - valid <= decode_op_bf_i | decode_op_bnf_i.
  - op_bf, op_bnf and pred_flag load unconditionally.
  - target and fallthru load only when a branch is captured.
- execute_op_bf_o = valid & op_bf. execute_op_bnf_o = valid & op_bnf. prev_op_brcond_o = valid.
- Resolution event R = valid & padv_decode_i & !pipeline_flush_i. This is the same condition on which the predictor updates its counter.
- taken = op_bf ? flag_i : !flag_i. mispredict = valid & (flag_i != pred_flag).
- On R:
  - branch_count increments, saturating at all-ones.
  - If mispredict, mispredict_count increments, saturating, and the redirect register loads.
  - The redirect register is redirect_valid_o <= 1 and redirect_addr_o <= taken ? target : fallthru.
- Redirect FSM:
  - IDLE: redirect_valid_o = 0. R & mispredict -> PENDING.
  - PENDING: redirect_valid_o = 1, redirect_addr_o held stable.
  - PENDING with redirect_ready_i and no new mispredict R -> IDLE.
  - PENDING with a new mispredict R, with or without ready -> stay PENDING with the new address (newest wins).
- pipeline_flush_i has highest priority:
  - valid <= 0 and FSM -> IDLE.
  - Counters unchanged; a branch resolving in a flush cycle is not counted.
- Inputs decode_op_bf_i & decode_op_bnf_i both high are illegal. If it happens, op_bf takes precedence for taken.

## Timing
- Reset (rst low, async): valid = 0, all exec outputs = 0, redirect_valid_o = 0, redirect_addr_o = 0, both counters = 0, FSM IDLE.
- Capture-to-execute latency: 1 cycle after the padv_decode_i edge.
- branch_mispredict_o is combinational in the same cycle as flag_i, with zero latency.
- redirect_valid_o rises on the clock edge that completes R. It holds until the edge where redirect_ready_i = 1, then drops on that edge.
- Counters update on the R edge and are visible on the next cycle.
- Saturation: at all-ones, further events leave the counter at all-ones.
- Back-to-back branches in consecutive decode advances are each resolved and counted.
- Reset mid-PENDING drops the request immediately (async).

## Test plan
- Predicted 1, l.bf, flag_i = 1 at resolve:
  - no mispredict, redirect_valid_o stays 0;
  - branch_count 0->1, mispredict_count 0.
- Predicted 1, l.bf, flag_i = 0, target 0x100, fallthru 0x208:
  - branch_mispredict_o high in the resolve cycle;
  - next cycle redirect_valid_o = 1, redirect_addr_o = 0x208, mispredict_count = 1.
- Predicted 1, l.bnf, flag_i = 0, target 0x400:
  - redirect to 0x400;
  - hold redirect_ready_i low 3 cycles: valid and address stable, then ready for 1 cycle, valid drops.
- PENDING with address 0x208, second mispredict resolves to 0x500 in the same cycle as ready:
  - stays PENDING with address 0x500;
  - mispredict_count increments by 1.
- pipeline_flush_i asserted with a branch in execute and a redirect pending:
  - valid, prev_op_brcond_o and redirect_valid_o go to 0 next cycle;
  - counters unchanged.
- CNT_WIDTH = 4, 20 mispredicting branches back to back:
  - both counters stop at 15;
  - async reset mid-sequence clears everything without a clock edge.
